aes_cmd_sequencer: RTL and testbench
====================================

Name: aes_cmd_sequencer

Overview:
- Command front-end directly upstream of the AES key-expansion and cipher cores.
- Accepts host commands (load key, encrypt block, decrypt block) over valid/ready.
- Drives the KeyBus and CipherBus handshakes to the cores, one command at a time.
- Returns each completion (data or error) through a small result FIFO with valid/ready output.

Parameters:
- RESULT_DEPTH, 4, result FIFO entries (power of 2, >=2)
- KEY_MODE, 2'b10, value driven on o_key_mode (256-bit key)
- TIMEOUT_CYCLES, 1024, max wait cycles for core completion before error

Ports:
- clk  in  1  global clock
- resetH  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  00 LOADKEY, 01 ENCRYPT, 10 DECRYPT, 11 reserved
- cmd_data  in  256  key (LOADKEY) or block in [127:0]
- o_key  out  256  key to expander
- o_key_mode  out  2  key mode
- o_start  out  1  one-cycle key-expansion start
- i_key_ready  in  1  expansion done
- o_data  out  128  block to cipher core
- o_data_valid  out  1  one-cycle block strobe
- o_ende  out  1  0 encrypt, 1 decrypt
- o_enable  out  1  cipher core enable
- i_ready  in  1  cipher core can accept
- i_data  in  128  cipher core result
- i_data_valid  in  1  result strobe
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_data  out  128  result block (0 for LOADKEY or error)
- res_op  out  2  op of the completed command
- res_err  out  1  1 = no key, timeout, or reserved op
- key_loaded  out  1  valid expanded key present

Behaviour:
- Reset (sync, resetH=1 at posedge):
  - State IDLE; FIFO emptied; key_loaded=0; timeout counter=0.
  - All outputs 0, except o_key_mode=KEY_MODE.
  - Reset mid-operation abandons the command; no result is pushed.
- cmd_ready = (state==IDLE) && (fifo_count < RESULT_DEPTH).
  - One command outstanding, so every accepted command is guaranteed a FIFO slot.
- States: IDLE, KEY_START, KEY_WAIT, CIPH_WAIT_READY, CIPH_ISSUE, CIPH_WAIT_RESULT, PUSH.
- From IDLE on accept:
  - LOADKEY -> KEY_START; register o_key=cmd_data.
  - ENC/DEC with key_loaded=1 -> CIPH_WAIT_READY; register o_data=cmd_data[127:0], o_ende=op[1].
  - ENC/DEC with key_loaded=0, or reserved op -> PUSH with err=1; no core activity.
- KEY_START: o_start=1 for exactly one cycle; key_loaded cleared; -> KEY_WAIT.
- KEY_WAIT: i_key_ready is ignored in the first cycle after start.
  - From the second cycle on, i_key_ready=1 -> key_loaded=1, PUSH (err=0).
- CIPH_WAIT_READY: o_enable=1; on i_ready=1 -> CIPH_ISSUE.
- CIPH_ISSUE: o_data_valid=1 for exactly one cycle; -> CIPH_WAIT_RESULT.
- CIPH_WAIT_RESULT: o_enable=1; i_data_valid=1 -> capture i_data, PUSH (err=0).
  - i_data_valid in CIPH_ISSUE or outside cipher states is ignored.
- o_enable=1 in all three CIPH_* states, 0 elsewhere.
- Timeout:
  - Counter runs in KEY_WAIT, CIPH_WAIT_READY and CIPH_WAIT_RESULT; cleared on state entry.
  - Reaching TIMEOUT_CYCLES -> PUSH with err=1, res_data=0.
  - A key-load timeout leaves key_loaded=0.
- PUSH: writes {data, op, err} to the FIFO in one cycle; -> IDLE.
  - The next command can be accepted the following cycle.
- Command latency:
  - LOADKEY: result visible at the earliest 4 cycles after accept.
  - Cipher: result visible 1 cycle after the i_data_valid capture, plus PUSH.
- Result FIFO:
  - res_valid = !empty; head drives res_* combinationally.
  - Pop on res_valid&&res_ready.
  - Simultaneous push and pop: count unchanged, data order kept.
  - Pointers wrap modulo RESULT_DEPTH; overflow is structurally impossible.
- A new LOADKEY always invalidates the previous key until completion.

Decomposition:
- Shared definitions package:
  - ulogic128 and ulogic256 (existing).
  - New enum aes_op_t {LOADKEY, ENCRYPT, DECRYPT, RSVD}.
  - Packed struct aes_result_t {ulogic128 data; aes_op_t op; logic err}.
- Sub-module aes_result_fifo: parameterised depth, element type aes_result_t, push/pop/count.
- FSM and timeout counter live in aes_cmd_sequencer.

Test Plan:
- Reset, then ENCRYPT 0x00112233445566778899aabbccddeeff before any LOADKEY -> one result, err=1, data=0, op=01; o_data_valid never asserted.
- LOADKEY 0x000102…1f; model asserts i_key_ready 10 cycles after o_start -> result op=00, err=0; key_loaded=1; o_start high exactly 1 cycle.
- After key load, ENCRYPT FIPS-197 block 00112233…eeff; model returns 8ea2b7ca516745bfeafc49904b496089 -> res_data matches; o_ende=0; one o_data_valid pulse after i_ready.
- DECRYPT 8ea2b7ca…6089 -> res_data=00112233…eeff, o_ende=1.
- res_ready held 0, issue 5 ENCRYPTs -> cmd_ready drops after 4 results; release res_ready -> results drain in order and the 5th command is accepted.
- Model never asserts i_data_valid with TIMEOUT_CYCLES=16 -> err result 16 cycles after issue; assert resetH mid-KEY_WAIT -> FIFO empty, key_loaded=0, all outputs 0.

Source files
------------

// File: rtl/aes_cmd_sequencer_pkg.sv
// Shared types for the AES command sequencer:
// operand widths, command opcodes, result record and FSM states.
package aes_cmd_sequencer_pkg;

  typedef logic [127:0] ulogic128;
  typedef logic [255:0] ulogic256;

  typedef enum logic [1:0] {
    LOADKEY = 2'b00,
    ENCRYPT = 2'b01,
    DECRYPT = 2'b10,
    RSVD    = 2'b11
  } aes_op_t;

  typedef struct packed {
    ulogic128 data;
    aes_op_t  op;
    logic     err;
  } aes_result_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    CIPH_WAIT_READY,
    CIPH_ISSUE,
    CIPH_WAIT_RESULT,
    PUSH
  } seq_state_t;

endpackage

// File: rtl/aes_result_fifo.sv
// Small result FIFO; head is presented combinationally.
// Depth is a power of two so pointers wrap naturally.
module aes_result_fifo
  import aes_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  aes_result_t push_data,
  input  logic        pop,
  output aes_result_t head,
  output logic        empty,
  output logic [AW:0] count
);

  aes_result_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          full;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Host command front-end for the AES key expander and cipher core.
// One command in flight; every completion lands in the result FIFO.
module aes_cmd_sequencer
  import aes_cmd_sequencer_pkg::*;
#(
  parameter int         RESULT_DEPTH   = 4,
  parameter logic [1:0] KEY_MODE       = 2'b10,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         resetH,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [255:0] cmd_data,
  output logic [255:0] o_key,
  output logic [1:0]   o_key_mode,
  output logic         o_start,
  input  logic         i_key_ready,
  output logic [127:0] o_data,
  output logic         o_data_valid,
  output logic         o_ende,
  output logic         o_enable,
  input  logic         i_ready,
  input  logic [127:0] i_data,
  input  logic         i_data_valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [1:0]   res_op,
  output logic         res_err,
  output logic         key_loaded
);

  localparam int AW = $clog2(RESULT_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t  state, state_n;
  aes_op_t     op;
  logic        accept;
  logic        timed_out;
  logic [TW-1:0] timer;

  ulogic256    key_reg;
  ulogic128    blk_reg;
  logic        ende_reg;
  logic        key_ok;
  ulogic128    pend_data, pend_data_n;
  aes_op_t     pend_op;
  logic        pend_err, pend_err_n;

  logic        ld_key, ld_blk, set_pend;
  logic        key_set, key_clr, fifo_push;

  aes_result_t fifo_head;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  assign op        = aes_op_t'(cmd_op);
  assign cmd_ready = !resetH && (state == IDLE) &&
                     (fifo_count < (AW+1)'(RESULT_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge clk) begin
    if (resetH) state <= IDLE;
    else        state <= state_n;
  end

  // next-state and per-state control strobes
  always_comb begin
    state_n     = state;
    ld_key      = 1'b0;
    ld_blk      = 1'b0;
    set_pend    = 1'b0;
    pend_data_n = '0;
    pend_err_n  = 1'b0;
    key_set     = 1'b0;
    key_clr     = 1'b0;
    fifo_push   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (op)
            LOADKEY: begin
              ld_key  = 1'b1;
              state_n = KEY_START;
            end
            ENCRYPT, DECRYPT: begin
              if (key_ok) begin
                ld_blk  = 1'b1;
                state_n = CIPH_WAIT_READY;
              end else begin
                set_pend   = 1'b1;
                pend_err_n = 1'b1;
                state_n    = PUSH;
              end
            end
            RSVD: begin
              set_pend   = 1'b1;
              pend_err_n = 1'b1;
              state_n    = PUSH;
            end
          endcase
        end
      end
      KEY_START: begin
        key_clr = 1'b1;
        state_n = KEY_WAIT;
      end
      KEY_WAIT: begin
        // first wait cycle ignores a stale ready from the expander
        if (i_key_ready && (timer != '0)) begin
          key_set  = 1'b1;
          set_pend = 1'b1;
          state_n  = PUSH;
        end else if (timed_out) begin
          set_pend   = 1'b1;
          pend_err_n = 1'b1;
          state_n    = PUSH;
        end
      end
      CIPH_WAIT_READY: begin
        if (i_ready) begin
          state_n = CIPH_ISSUE;
        end else if (timed_out) begin
          set_pend   = 1'b1;
          pend_err_n = 1'b1;
          state_n    = PUSH;
        end
      end
      CIPH_ISSUE: begin
        state_n = CIPH_WAIT_RESULT;
      end
      CIPH_WAIT_RESULT: begin
        if (i_data_valid) begin
          set_pend    = 1'b1;
          pend_data_n = i_data;
          state_n     = PUSH;
        end else if (timed_out) begin
          set_pend   = 1'b1;
          pend_err_n = 1'b1;
          state_n    = PUSH;
        end
      end
      PUSH: begin
        fifo_push = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // wait timer: cleared on every state change, runs in wait states
  always_ff @(posedge clk) begin
    if (resetH) begin
      timer <= '0;
    end else if (state_n != state) begin
      timer <= '0;
    end else if (state == KEY_WAIT || state == CIPH_WAIT_READY ||
                 state == CIPH_WAIT_RESULT) begin
      timer <= timer + TW'(1);
    end
  end

  // command operands, key validity and pending result record
  always_ff @(posedge clk) begin
    if (resetH) begin
      key_reg   <= '0;
      blk_reg   <= '0;
      ende_reg  <= 1'b0;
      key_ok    <= 1'b0;
      pend_data <= '0;
      pend_op   <= LOADKEY;
      pend_err  <= 1'b0;
    end else begin
      if (ld_key) key_reg <= cmd_data;
      if (ld_blk) begin
        blk_reg  <= cmd_data[127:0];
        ende_reg <= cmd_op[1];
      end
      if (accept) pend_op <= op;
      if (set_pend) begin
        pend_data <= pend_data_n;
        pend_err  <= pend_err_n;
      end
      if (key_clr)      key_ok <= 1'b0;
      else if (key_set) key_ok <= 1'b1;
    end
  end

  aes_result_fifo #(
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (resetH),
    .push      (fifo_push),
    .push_data ('{data: pend_data, op: pend_op, err: pend_err}),
    .pop       (res_valid && res_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_key        = key_reg;
  assign o_key_mode   = KEY_MODE;
  assign o_start      = (state == KEY_START);
  assign o_data       = blk_reg;
  assign o_data_valid = (state == CIPH_ISSUE);
  assign o_ende       = ende_reg;
  assign o_enable     = (state == CIPH_WAIT_READY) ||
                        (state == CIPH_ISSUE) ||
                        (state == CIPH_WAIT_RESULT);
  assign key_loaded   = key_ok;
  assign res_valid    = !fifo_empty;
  assign res_data     = fifo_head.data;
  assign res_op       = fifo_head.op;
  assign res_err      = fifo_head.err;

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Bench for aes_cmd_sequencer: core models plus a result scoreboard.
// Expected results are queued on accept and checked on each pop.
module tb_aes_cmd_sequencer;
  import aes_cmd_sequencer_pkg::*;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 0;
  logic         resetH = 1;
  logic         cmd_valid = 0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 0;
  logic [255:0] cmd_data = 0;
  logic [255:0] o_key;
  logic [1:0]   o_key_mode;
  logic         o_start;
  logic         i_key_ready = 0;
  logic [127:0] o_data;
  logic         o_data_valid;
  logic         o_ende;
  logic         o_enable;
  logic         i_ready = 0;
  logic [127:0] i_data = 0;
  logic         i_data_valid = 0;
  logic         res_valid;
  logic         res_ready = 1;
  logic [127:0] res_data;
  logic [1:0]   res_op;
  logic         res_err;
  logic         key_loaded;

  int total = 0;
  int bad = 0;
  aes_result_t exp_q[$];

  bit key_hang = 0;
  bit cipher_hang = 0;
  int kcnt = 0, dcnt = 0, en_cnt = 0;
  int start_cnt = 0, dv_cnt = 0;
  int cyc = 0, dv_cyc = 0;
  logic [127:0] cap_data = 0;
  logic cap_ende = 0;

  aes_cmd_sequencer #(
    .RESULT_DEPTH   (4),
    .KEY_MODE       (2'b10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .resetH       (resetH),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .o_key        (o_key),
    .o_key_mode   (o_key_mode),
    .o_start      (o_start),
    .i_key_ready  (i_key_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_ende       (o_ende),
    .o_enable     (o_enable),
    .i_ready      (i_ready),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_op       (res_op),
    .res_err      (res_err),
    .key_loaded   (key_loaded)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_f(input logic [127:0] d,
                                          input logic e);
    if (!e && d == PT) return CT;
    if (e && d == CT) return PT;
    return e ? {d[63:0], d[127:64]} : ~d;
  endfunction

  // key expander and cipher core behavioural models
  always @(posedge clk) begin
    #1;
    cyc++;
    i_key_ready  = 0;
    i_data_valid = 0;
    if (resetH) begin
      kcnt = 0; dcnt = 0; en_cnt = 0; i_ready = 0;
    end else begin
      if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0 && !key_hang) i_key_ready = 1;
      end
      if (o_start) begin
        kcnt = 10;
        start_cnt++;
      end
      en_cnt  = o_enable ? en_cnt + 1 : 0;
      i_ready = (en_cnt >= 3);
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0 && !cipher_hang) begin
          i_data_valid = 1;
          i_data = core_f(cap_data, cap_ende);
        end
      end
      if (o_data_valid) begin
        dv_cnt++;
        dv_cyc = cyc;
        cap_data = o_data;
        cap_ende = o_ende;
        dcnt = 3;
      end
    end
  end

  // scoreboard: every popped result must match the oldest expectation
  always @(negedge clk) begin
    if (!resetH && res_valid && res_ready) begin
      aes_result_t got, exp;
      got = '{data: res_data, op: aes_op_t'(res_op), err: res_err};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected got=%h", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL result got=%h want=%h", got, exp);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [255:0] d,
                      input string tag);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_accept got=0 want=1", tag);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d want=0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset;
    resetH = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 10;
    if (o_key !== '0) begin bad++; $display("FAIL rst_o_key got=%h want=0", o_key); end
    if (o_key_mode !== 2'b10) begin bad++; $display("FAIL rst_key_mode got=%b want=10", o_key_mode); end
    if (o_start !== 0) begin bad++; $display("FAIL rst_o_start got=%b want=0", o_start); end
    if (o_data !== '0) begin bad++; $display("FAIL rst_o_data got=%h want=0", o_data); end
    if (o_data_valid !== 0) begin bad++; $display("FAIL rst_o_data_valid got=%b want=0", o_data_valid); end
    if (o_ende !== 0) begin bad++; $display("FAIL rst_o_ende got=%b want=0", o_ende); end
    if (o_enable !== 0) begin bad++; $display("FAIL rst_o_enable got=%b want=0", o_enable); end
    if (res_valid !== 0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
    if (key_loaded !== 0) begin bad++; $display("FAIL rst_key_loaded got=%b want=0", key_loaded); end
    if (cmd_ready !== 0) begin bad++; $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); end
    @(posedge clk); #1;
    resetH = 0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1) begin bad++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_nokey;
    dv_cnt = 0;
    exp_q.push_back('{data: '0, op: ENCRYPT, err: 1'b1});
    send(2'b01, {128'h0, PT}, "nokey");
    wait_drain("nokey");
    total++;
    if (dv_cnt !== 0) begin bad++; $display("FAIL nokey_dv got=%0d want=0", dv_cnt); end
  endtask

  task automatic test_rsvd;
    exp_q.push_back('{data: '0, op: RSVD, err: 1'b1});
    send(2'b11, {128'h0, PT}, "rsvd");
    wait_drain("rsvd");
  endtask

  task automatic test_loadkey;
    start_cnt = 0;
    exp_q.push_back('{data: '0, op: LOADKEY, err: 1'b0});
    send(2'b00, KEY, "loadkey");
    wait_drain("loadkey");
    total += 3;
    if (key_loaded !== 1) begin bad++; $display("FAIL key_loaded got=%b want=1", key_loaded); end
    if (start_cnt !== 1) begin bad++; $display("FAIL start_pulse got=%0d want=1", start_cnt); end
    if (o_key !== KEY) begin bad++; $display("FAIL o_key got=%h want=%h", o_key, KEY); end
  endtask

  task automatic test_cipher(input logic [1:0] op, input logic [127:0] din,
                             input logic [127:0] dout, input logic ende,
                             input string tag);
    dv_cnt = 0;
    exp_q.push_back('{data: dout, op: aes_op_t'(op), err: 1'b0});
    send(op, {128'h0, din}, tag);
    wait_drain(tag);
    total += 3;
    if (dv_cnt !== 1) begin bad++; $display("FAIL %s_dv got=%0d want=1", tag, dv_cnt); end
    if (cap_ende !== ende) begin bad++; $display("FAIL %s_ende got=%b want=%b", tag, cap_ende, ende); end
    if (cap_data !== din) begin bad++; $display("FAIL %s_o_data got=%h want=%h", tag, cap_data, din); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] d;
    bit seen = 0;
    res_ready = 0;
    for (int i = 0; i < 4; i++) begin
      d = {32'(i), 96'($urandom())};
      exp_q.push_back('{data: ~d, op: ENCRYPT, err: 1'b0});
      send(2'b01, {128'h0, d}, "b2b");
    end
    repeat (30) @(posedge clk);
    #1;
    d = {32'h5, 96'($urandom())};
    cmd_valid = 1; cmd_op = 2'b01; cmd_data = {128'h0, d};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
    end
    total += 2;
    if (seen) begin bad++; $display("FAIL b2b_full_ready got=1 want=0"); end
    if (res_valid !== 1) begin bad++; $display("FAIL b2b_res_valid got=%b want=1", res_valid); end
    exp_q.push_back('{data: ~d, op: ENCRYPT, err: 1'b0});
    @(posedge clk); #1;
    res_ready = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_fifth_accept got=0 want=1"); end
    wait_drain("b2b");
  endtask

  task automatic test_timeout;
    int lat = -1;
    cipher_hang = 1;
    dv_cyc = -1000;
    exp_q.push_back('{data: '0, op: ENCRYPT, err: 1'b1});
    send(2'b01, {128'h0, PT}, "tmo");
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = cyc - dv_cyc;
    end
    total++;
    if (lat < 16 || lat > 19) begin
      bad++;
      $display("FAIL tmo_latency got=%0d want=16..19", lat);
    end
    wait_drain("tmo");
    cipher_hang = 0;
  endtask

  task automatic test_reset_mid;
    int s0;
    bit seen_rv = 0;
    key_hang = 1;
    s0 = start_cnt;
    send(2'b00, ~KEY, "rstmid");
    for (int i = 0; i < 20 && start_cnt == s0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    resetH = 1;
    @(posedge clk);
    @(negedge clk);
    total += 6;
    if (res_valid !== 0) begin bad++; $display("FAIL rstmid_res_valid got=%b want=0", res_valid); end
    if (key_loaded !== 0) begin bad++; $display("FAIL rstmid_key_loaded got=%b want=0", key_loaded); end
    if (o_key !== '0) begin bad++; $display("FAIL rstmid_o_key got=%h want=0", o_key); end
    if (o_start !== 0) begin bad++; $display("FAIL rstmid_o_start got=%b want=0", o_start); end
    if (o_enable !== 0) begin bad++; $display("FAIL rstmid_o_enable got=%b want=0", o_enable); end
    if (o_data !== '0) begin bad++; $display("FAIL rstmid_o_data got=%h want=0", o_data); end
    @(posedge clk); #1;
    resetH = 0;
    key_hang = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) seen_rv = 1;
    end
    total++;
    if (seen_rv) begin bad++; $display("FAIL rstmid_no_result got=1 want=0"); end
  endtask

  initial begin
    test_reset();
    test_nokey();
    test_rsvd();
    test_loadkey();
    test_cipher(2'b01, PT, CT, 1'b0, "enc");
    test_cipher(2'b10, CT, PT, 1'b1, "dec");
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
